glitch_pulse_router: RTL and testbench
======================================

Name: glitch_pulse_router

Overview:
- Parametrised successor to the fixed 5-output glitch mux/force logic.
- Takes a single-cycle glitch-start strobe from the command block and drives NUM_CH output pins.
- Each channel has its own route enable, delay offset, pulse width, force level and polarity.
- Sits between the command/trigger logic and the pad outputs (glitch SMA, MAX4619 selects, auxout), on the 100 MHz sysclk domain.

Parameters:
- NUM_CH, 8, number of output channels (1..16).
- DELAY_W, 16, width of the per-channel delay counter (cycles).
- WIDTH_W, 16, width of the per-channel pulse-width counter (cycles).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- i_cfg_we  in  1  config write strobe, one cycle.
- i_cfg_addr  in  clog2(NUM_CH) (min 1)  channel index for the write.
- i_cfg_en  in  1  route enable for the addressed channel.
- i_cfg_force  in  1  static force-high for the channel.
- i_cfg_invert  in  1  output polarity invert.
- i_cfg_delay  in  DELAY_W  delay from trigger to pulse start (cycles).
- i_cfg_width  in  WIDTH_W  pulse length (cycles); 0 means no pulse.
- i_arm  in  1  arm request, one cycle.
- i_abort  in  1  abort; returns all channels and the FSM to idle.
- i_trig  in  1  glitch-start strobe, already synchronous to clk.
- o_out  out  NUM_CH  registered channel outputs.
- o_armed  out  1  FSM is in ARMED.
- o_busy  out  1  FSM is in FIRING.
- o_done  out  1  one-cycle pulse when firing completes.

Behaviour:
- Reset: all config fields 0 (disabled, width 0, no force, no invert); FSM DISARMED; o_out=0, o_armed=0, o_busy=0, o_done=0.
- Config:
  - A write at edge E updates the addressed channel's fields at E.
  - Writes with i_cfg_addr >= NUM_CH are ignored.
  - force/invert take effect on o_out at E+1.
  - delay/width/en are copied into the channel counters only at trigger, so a write during FIRING affects the next shot only.
- Global FSM (DISARMED, ARMED, FIRING):
  - DISARMED -> ARMED on i_arm.
  - ARMED -> FIRING on i_trig. Triggers while DISARMED or FIRING are ignored; i_arm while ARMED or FIRING is ignored.
  - FIRING -> DISARMED when all channels are idle. o_done=1 for exactly that one cycle.
  - Single shot: re-arm is required before the next trigger.
- Channel FSM (IDLE, DELAY, PULSE):
  - Trigger sampled at edge T. Channels with en=1 and width>0 load their counters at T.
  - Pulse is active on o_out for exactly W cycles, edges T+1+D through T+D+W inclusive; it falls at T+1+D+W.
  - Channels that are disabled or have W=0 remain IDLE.
- Done timing:
  - Completion edge = T+1+max(D+W) over participating channels; o_busy falls and o_done rises on that edge.
  - With no participating channels, o_done fires at T+1 and o_busy never asserts.
- Output equation: o_out[k] = (pulse_k | force_k) XOR invert_k, registered.
- Simultaneous events:
  - i_abort wins over i_trig and i_arm. Abort clears all channels and returns the FSM to DISARMED next edge; o_done is not asserted.
  - i_cfg_we on the trigger edge: the trigger loads the old values.
  - i_arm and i_trig on the same edge while DISARMED: arm only.
- Counter arithmetic: unsigned, no wrap. The max delay of 2^DELAY_W-1 is legal.
- rst_n asserted mid-pulse drops o_out to 0 immediately, since reset is asynchronous.

Decomposition:
- Shared package holds:
  - the global state encoding (ST_DISARMED, ST_ARMED, ST_FIRING);
  - the channel state encoding (CH_IDLE, CH_DELAY, CH_PULSE);
  - the default parameter constants.
- One sub-module, glitch_pulse_channel: config registers, delay/width counters and output register for a single channel, instantiated NUM_CH times by generate.
- The top holds the global FSM and the done/any-active reduction.

Test Plan:
- Reset with rst_n=0 then release -> o_out=0, o_armed=0, o_busy=0, o_done=0; config writes made before arming have no effect on o_out except force/invert.
- ch0 en, D=0, W=3; arm, trig at T -> o_out[0] high at T+1..T+3, low at T+4; o_done at T+4; o_busy high T+1..T+3.
- ch1 D=5, W=2; ch2 D=0, W=10; trig at T -> o_out[1] high T+6..T+7, o_out[2] high T+1..T+10; o_done single cycle at T+11.
- ch3 force=1, invert=1, en=0 -> o_out[3]=0 static. Clearing force gives o_out[3]=1. Triggering leaves o_out[3] unchanged.
- Second trig while FIRING, and trig while DISARMED -> ignored, with no output change. i_abort at T+2 with ch0 W=10 -> o_out[0] low at T+3, FSM DISARMED, no o_done.
- Write ch0 W=7 during FIRING of a W=3 shot -> current pulse stays 3 cycles; the next armed shot is 7 cycles. Write to addr=NUM_CH -> no config change.

Source files
------------

// File: rtl/glitch_pulse_router_pkg.sv
// glitch_pulse_router_pkg
// Shared definitions for the glitch pulse router: default parameter values,
// the global arm/fire state encoding, the per-channel state encoding and the
// output-level helper used by every channel.
package glitch_pulse_router_pkg;

   localparam int DEF_NUM_CH  = 8;
   localparam int DEF_DELAY_W = 16;
   localparam int DEF_WIDTH_W = 16;

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_FIRING   = 2'd2
   } globalState_t;

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_DELAY = 2'd1,
      CH_PULSE = 2'd2
   } chanState_t;

   // Pin level for a channel: the pulse or a static force, then polarity.
   function automatic logic outLevel(input logic pulse, input logic frc, input logic inv);
      return (pulse | frc) ^ inv;
   endfunction

endpackage

// File: rtl/glitch_pulse_channel.sv
// glitch_pulse_channel
// One output channel: holds its config registers, runs the delay and width
// counters for a single shot, and registers the pin level.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_we             config write strobe for this channel
//   i_en, i_force, i_invert, i_delay, i_width   config fields
//   i_fire           trigger accepted this edge (load counters)
//   i_abort          return to idle immediately
//   o_out            registered pin level
//   o_activeNext     channel will still be delaying/pulsing after this edge
module glitch_pulse_channel
   import glitch_pulse_router_pkg::*;
#(
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_we,
   input  logic               i_en,
   input  logic               i_force,
   input  logic               i_invert,
   input  logic [DELAY_W-1:0] i_delay,
   input  logic [WIDTH_W-1:0] i_width,
   input  logic               i_fire,
   input  logic               i_abort,
   output logic               o_out,
   output logic               o_activeNext
);

   logic               r_en;
   logic               r_force;
   logic               r_invert;
   logic [DELAY_W-1:0] r_delay;
   logic [WIDTH_W-1:0] r_width;
   chanState_t         r_state;
   logic [DELAY_W-1:0] r_delayCnt;
   logic [WIDTH_W-1:0] r_widthCnt;
   logic               r_out;

   assign o_out = r_out;

   // The global FSM asks at each edge whether anything is still running after
   // it; a pulse whose remaining count is zero ends on this very edge.
   assign o_activeNext = (r_state == CH_DELAY) ||
                         ((r_state == CH_PULSE) && (r_widthCnt != '0));

   // Config registers. Delay/width/enable are only read when a trigger loads
   // the counters, so rewriting them mid-shot only affects the next shot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en     <= 1'b0;
         r_force  <= 1'b0;
         r_invert <= 1'b0;
         r_delay  <= '0;
         r_width  <= '0;
      end else if (i_we) begin
         r_en     <= i_en;
         r_force  <= i_force;
         r_invert <= i_invert;
         r_delay  <= i_delay;
         r_width  <= i_width;
      end
   end

   // Shot sequencer. The delay counter holds the edges still to wait; the
   // width counter is pre-decremented on entering PULSE so that a zero count
   // in PULSE means this edge is the one where the pulse drops. The pin level
   // uses the force/invert registers as they stood before this edge, so a
   // config write shows on the pin one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= CH_IDLE;
         r_delayCnt <= '0;
         r_widthCnt <= '0;
         r_out      <= 1'b0;
      end else if (i_abort) begin
         r_state <= CH_IDLE;
         r_out   <= outLevel(1'b0, r_force, r_invert);
      end else begin
         case (r_state)
            CH_IDLE: begin
               r_out <= outLevel(1'b0, r_force, r_invert);
               if (i_fire && r_en && (r_width != '0)) begin
                  r_state    <= CH_DELAY;
                  r_delayCnt <= r_delay;
                  r_widthCnt <= r_width;
               end
            end
            CH_DELAY: begin
               if (r_delayCnt == '0) begin
                  r_state    <= CH_PULSE;
                  r_widthCnt <= r_widthCnt - WIDTH_W'(1);
                  r_out      <= outLevel(1'b1, r_force, r_invert);
               end else begin
                  r_delayCnt <= r_delayCnt - DELAY_W'(1);
                  r_out      <= outLevel(1'b0, r_force, r_invert);
               end
            end
            CH_PULSE: begin
               if (r_widthCnt == '0) begin
                  r_state <= CH_IDLE;
                  r_out   <= outLevel(1'b0, r_force, r_invert);
               end else begin
                  r_widthCnt <= r_widthCnt - WIDTH_W'(1);
                  r_out      <= outLevel(1'b1, r_force, r_invert);
               end
            end
            default: begin
               r_state <= CH_IDLE;
               r_out   <= outLevel(1'b0, r_force, r_invert);
            end
         endcase
      end
   end

endmodule

// File: rtl/glitch_pulse_router.sv
// glitch_pulse_router
// Routes a single-cycle glitch-start strobe to NUM_CH output pins, each with
// its own enable, delay, pulse width, force level and polarity. A global
// single-shot FSM (DISARMED -> ARMED -> FIRING -> DISARMED) gates the trigger.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_cfg_we/addr       config write strobe and channel index
//   i_cfg_en/force/invert/delay/width   config fields for the addressed channel
//   i_arm, i_abort, i_trig              control strobes
//   o_out               registered channel pins
//   o_armed, o_busy     FSM in ARMED / FIRING with channels running
//   o_done              one-cycle pulse when a shot completes
module glitch_pulse_router
   import glitch_pulse_router_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int DELAY_W = DEF_DELAY_W,
   parameter int WIDTH_W = DEF_WIDTH_W
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          i_cfg_we,
   input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0]  i_cfg_addr,
   input  logic                                          i_cfg_en,
   input  logic                                          i_cfg_force,
   input  logic                                          i_cfg_invert,
   input  logic [DELAY_W-1:0]                            i_cfg_delay,
   input  logic [WIDTH_W-1:0]                            i_cfg_width,
   input  logic                                          i_arm,
   input  logic                                          i_abort,
   input  logic                                          i_trig,
   output logic [NUM_CH-1:0]                             o_out,
   output logic                                          o_armed,
   output logic                                          o_busy,
   output logic                                          o_done
);

   localparam int ADDR_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);

   globalState_t      r_state;
   logic              r_armed;
   logic              r_busy;
   logic              r_done;
   logic [NUM_CH-1:0] w_chanWe;
   logic [NUM_CH-1:0] w_activeNext;
   logic [NUM_CH-1:0] w_out;
   logic              w_fire;
   logic              w_anyActive;

   // A trigger is only accepted while armed, and abort overrides it.
   assign w_fire      = (r_state == ST_ARMED) && i_trig && !i_abort;
   assign w_anyActive = |w_activeNext;

   assign o_out   = w_out;
   assign o_armed = r_armed;
   assign o_busy  = r_busy;
   assign o_done  = r_done;

   // Addresses at or beyond NUM_CH match no channel and are dropped.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      assign w_chanWe[k] = i_cfg_we && (i_cfg_addr == ADDR_W'(k));

      glitch_pulse_channel #(
         .DELAY_W (DELAY_W),
         .WIDTH_W (WIDTH_W)
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .i_we         (w_chanWe[k]),
         .i_en         (i_cfg_en),
         .i_force      (i_cfg_force),
         .i_invert     (i_cfg_invert),
         .i_delay      (i_cfg_delay),
         .i_width      (i_cfg_width),
         .i_fire       (w_fire),
         .i_abort      (i_abort),
         .o_out        (w_out[k]),
         .o_activeNext (w_activeNext[k])
      );
   end

   // Global single-shot FSM. Busy is raised from the first edge after the
   // trigger while any channel keeps running; the edge on which the last
   // channel finishes drops busy, pulses done and disarms. A shot with no
   // participating channels therefore completes on the edge after the trigger
   // without ever showing busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_DISARMED;
         r_armed <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_abort) begin
            r_state <= ST_DISARMED;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_DISARMED: begin
                  if (i_arm) begin
                     r_state <= ST_ARMED;
                     r_armed <= 1'b1;
                  end
               end
               ST_ARMED: begin
                  if (i_trig) begin
                     r_state <= ST_FIRING;
                     r_armed <= 1'b0;
                  end
               end
               ST_FIRING: begin
                  if (!w_anyActive) begin
                     r_state <= ST_DISARMED;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_busy <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_DISARMED;
                  r_armed <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glitch_pulse_router.sv
// tb_glitch_pulse_router
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences and a randomized phase, all compared every cycle against a
// window-based reference model of the router.
module tb_glitch_pulse_router;

   localparam int NCH = 6;
   localparam int DW  = 8;
   localparam int WW  = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           weIn, enIn, frcIn, invIn, armIn, abortIn, trigIn;
   logic [2:0]     addrIn;
   logic [DW-1:0]  dlyIn;
   logic [WW-1:0]  widIn;
   logic [NCH-1:0] dutOut;
   logic           dutArmed, dutBusy, dutDone;

   int nChecks = 0;
   int nFail   = 0;
   int cyc     = 0;

   // Reference model: config as plain arrays, each participating channel's
   // pulse as an absolute [start, end] edge window computed at trigger time.
   bit mEn[NCH], mForce[NCH], mInv[NCH], mValid[NCH];
   int mD[NCH], mW[NCH], mStart[NCH], mEnd[NCH];
   int mState;
   int mT, mDoneEdge;
   logic [NCH-1:0] expOut;
   bit expArmed, expBusy, expDone;

   typedef struct {
      bit we; int addr; bit en; bit frc; bit inv; int dly; int wid;
      bit arm; bit abort; bit trig;
      logic [NCH-1:0] eOut; bit eArmed; bit eBusy; bit eDone;
   } vec_t;

   vec_t vecs[13];

   glitch_pulse_router #(.NUM_CH(NCH), .DELAY_W(DW), .WIDTH_W(WW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cfg_we(weIn), .i_cfg_addr(addrIn), .i_cfg_en(enIn),
      .i_cfg_force(frcIn), .i_cfg_invert(invIn),
      .i_cfg_delay(dlyIn), .i_cfg_width(widIn),
      .i_arm(armIn), .i_abort(abortIn), .i_trig(trigIn),
      .o_out(dutOut), .o_armed(dutArmed), .o_busy(dutBusy), .o_done(dutDone)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(bit we, int addr, bit en, bit frc, bit inv, int dly, int wid,
                                  bit arm, bit abort, bit trig,
                                  logic [NCH-1:0] eOut, bit eArmed, bit eBusy, bit eDone);
      vec_t v;
      v.we = we; v.addr = addr; v.en = en; v.frc = frc; v.inv = inv; v.dly = dly; v.wid = wid;
      v.arm = arm; v.abort = abort; v.trig = trig;
      v.eOut = eOut; v.eArmed = eArmed; v.eBusy = eBusy; v.eDone = eDone;
      return v;
   endfunction

   task automatic clearInputs();
      weIn = 0; addrIn = '0; enIn = 0; frcIn = 0; invIn = 0; dlyIn = '0; widIn = '0;
      armIn = 0; abortIn = 0; trigIn = 0;
   endtask

   task automatic modelReset();
      for (int k = 0; k < NCH; k++) begin
         mEn[k] = 0; mForce[k] = 0; mInv[k] = 0; mValid[k] = 0;
         mD[k] = 0; mW[k] = 0; mStart[k] = 0; mEnd[k] = -1;
      end
      mState = 0; mT = 0; mDoneEdge = -1;
   endtask

   // One clock edge of the model, using the inputs the DUT just sampled.
   task automatic modelEdge();
      int n;
      int mx;
      n = cyc;
      expDone = 0;
      if (abortIn) begin
         mState = 0;
         for (int k = 0; k < NCH; k++) mValid[k] = 0;
      end else begin
         case (mState)
            0: if (armIn) mState = 1;
            1: if (trigIn) begin
               mState = 2; mT = n; mx = 0;
               for (int k = 0; k < NCH; k++) begin
                  mValid[k] = mEn[k] && (mW[k] > 0);
                  if (mValid[k]) begin
                     mStart[k] = n + 1 + mD[k];
                     mEnd[k]   = n + mD[k] + mW[k];
                     if (mD[k] + mW[k] > mx) mx = mD[k] + mW[k];
                  end
               end
               mDoneEdge = n + 1 + mx;
            end
            default: if (n == mDoneEdge) begin
               mState = 0; expDone = 1;
            end
         endcase
      end
      expArmed = (mState == 1);
      expBusy  = (mState == 2) && (n > mT);
      for (int k = 0; k < NCH; k++)
         expOut[k] = ((mValid[k] && n >= mStart[k] && n <= mEnd[k]) | mForce[k]) ^ mInv[k];
      if (weIn && int'(addrIn) < NCH) begin
         mEn[addrIn] = enIn; mForce[addrIn] = frcIn; mInv[addrIn] = invIn;
         mD[addrIn] = int'(dlyIn); mW[addrIn] = int'(widIn);
      end
   endtask

   task automatic compareExp(string name, logic [NCH-1:0] eOut, bit eArmed, bit eBusy, bit eDone);
      nChecks += 4;
      if (dutOut !== eOut) begin
         nFail++; $display("[TB] FAIL %s o_out cyc=%0d got %b want %b", name, cyc, dutOut, eOut);
      end
      if (dutArmed !== eArmed) begin
         nFail++; $display("[TB] FAIL %s o_armed cyc=%0d got %b want %b", name, cyc, dutArmed, eArmed);
      end
      if (dutBusy !== eBusy) begin
         nFail++; $display("[TB] FAIL %s o_busy cyc=%0d got %b want %b", name, cyc, dutBusy, eBusy);
      end
      if (dutDone !== eDone) begin
         nFail++; $display("[TB] FAIL %s o_done cyc=%0d got %b want %b", name, cyc, dutDone, eDone);
      end
   endtask

   task automatic checkOutput(string name);
      compareExp(name, expOut, expArmed, expBusy, expDone);
   endtask

   task automatic checkVal(string name, int got, int want);
      nChecks++;
      if (got != want) begin
         nFail++; $display("[TB] FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      modelEdge();
      #1;
      checkOutput("model");
   endtask

   task automatic applyStimulus(vec_t v);
      weIn = v.we; addrIn = 3'(v.addr); enIn = v.en; frcIn = v.frc; invIn = v.inv;
      dlyIn = DW'(v.dly); widIn = WW'(v.wid);
      armIn = v.arm; abortIn = v.abort; trigIn = v.trig;
      step();
      clearInputs();
   endtask

   task automatic cfgWrite(int addr, bit en, bit frc, bit inv, int dly, int wid);
      weIn = 1; addrIn = 3'(addr); enIn = en; frcIn = frc; invIn = inv;
      dlyIn = DW'(dly); widIn = WW'(wid);
      step();
      clearInputs();
   endtask

   task automatic doArm();
      armIn = 1; step(); clearInputs();
   endtask

   task automatic doTrig();
      trigIn = 1; step(); clearInputs();
   endtask

   task automatic stepCount(int n, int ch, output int hi, output int dones);
      hi = 0; dones = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (dutOut[ch]) hi++;
         if (dutDone) dones++;
      end
   endtask

   initial begin
      int hi, dones, hi2, d2, tEdge, doneAt;
      logic [NCH-1:0] snap;

      clearInputs();
      modelReset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      compareExp("reset", '0, 0, 0, 0);
      rst_n = 1;

      // Directed table: ch0 D=0 W=3 shot plus ch3 force/invert behaviour.
      vecs[0]  = mkVec(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 6'b000000, 0, 0, 0);
      vecs[1]  = mkVec(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vecs[2]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vecs[3]  = mkVec(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
      vecs[4]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0);
      vecs[5]  = mkVec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001000, 1, 0, 0);
      vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 0, 0);
      vecs[7]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 1, 0);
      vecs[8]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 1, 0);
      vecs[9]  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001001, 0, 1, 0);
      vecs[10] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 1);
      vecs[11] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000, 0, 0, 0);
      vecs[12] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b001000, 0, 0, 0);
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         compareExp($sformatf("vec%0d", i), vecs[i].eOut, vecs[i].eArmed, vecs[i].eBusy, vecs[i].eDone);
      end

      // Two channels with different windows; a second trigger while firing.
      cfgWrite(0, 0, 0, 0, 0, 0);
      cfgWrite(1, 1, 0, 0, 5, 2);
      cfgWrite(2, 1, 0, 0, 0, 10);
      doArm();
      doTrig();
      tEdge = cyc; dones = 0; doneAt = -1; hi = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 2) trigIn = 1;
         step();
         clearInputs();
         if (dutOut[1]) hi++;
         if (dutDone) begin dones++; doneAt = cyc - tEdge; end
      end
      checkVal("twoCh doneCount", dones, 1);
      checkVal("twoCh doneAt", doneAt, 11);
      checkVal("twoCh ch1Width", hi, 2);

      // Abort mid-pulse.
      cfgWrite(1, 0, 0, 0, 0, 0);
      cfgWrite(2, 0, 0, 0, 0, 0);
      cfgWrite(0, 1, 0, 0, 0, 10);
      doArm();
      doTrig();
      step(); step();
      abortIn = 1; step(); clearInputs();
      checkVal("abort out0", int'(dutOut[0]), 0);
      checkVal("abort busy", int'(dutBusy), 0);
      stepCount(12, 0, hi, dones);
      checkVal("abort noDone", dones, 0);
      checkVal("abort noPulse", hi, 0);

      // Rewriting width mid-shot only affects the next shot.
      cfgWrite(0, 1, 0, 0, 0, 3);
      doArm();
      doTrig();
      weIn = 1; addrIn = 3'd0; enIn = 1; widIn = 8'd7;
      stepCount(1, 0, hi, dones);
      clearInputs();
      stepCount(6, 0, hi2, d2);
      checkVal("midWrite curWidth", hi + hi2, 3);
      doArm();
      doTrig();
      stepCount(10, 0, hi, dones);
      checkVal("midWrite nextWidth", hi, 7);

      // Out-of-range addresses change nothing.
      snap = dutOut;
      cfgWrite(6, 1, 1, 1, 0, 5);
      cfgWrite(7, 1, 1, 0, 0, 5);
      step(); step();
      checkVal("badAddr out", int'(dutOut), int'(snap));

      // Config write on the trigger edge: old width is loaded.
      cfgWrite(0, 1, 0, 0, 0, 3);
      doArm();
      weIn = 1; addrIn = 3'd0; enIn = 1; widIn = 8'd6; trigIn = 1;
      step(); clearInputs();
      stepCount(9, 0, hi, dones);
      checkVal("trigWrite width", hi, 3);

      // Arm and trigger together while disarmed: arm only.
      armIn = 1; trigIn = 1; step(); clearInputs();
      checkVal("armTrig armed", int'(dutArmed), 1);
      step();
      checkVal("armTrig busy", int'(dutBusy), 0);
      abortIn = 1; step(); clearInputs();
      checkVal("abortArmed armed", int'(dutArmed), 0);

      // Maximum delay on ch4.
      cfgWrite(0, 0, 0, 0, 0, 0);
      cfgWrite(4, 1, 0, 0, 255, 1);
      doArm();
      doTrig();
      stepCount(260, 4, hi, dones);
      checkVal("maxDelay width", hi, 1);
      checkVal("maxDelay done", dones, 1);

      // Asynchronous reset mid-pulse.
      cfgWrite(0, 1, 0, 0, 0, 10);
      doArm();
      doTrig();
      step(); step(); step();
      #2 rst_n = 0;
      #1;
      compareExp("asyncReset", '0, 0, 0, 0);
      rst_n = 1;
      modelReset();

      // No participating channels: done on the next edge, never busy.
      doArm();
      doTrig();
      step();
      checkVal("noPart done", int'(dutDone), 1);
      checkVal("noPart busy", int'(dutBusy), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         weIn    = ($urandom_range(0, 4) == 0);
         addrIn  = 3'($urandom_range(0, 7));
         enIn    = ($urandom_range(0, 3) != 0);
         frcIn   = ($urandom_range(0, 7) == 0);
         invIn   = ($urandom_range(0, 7) == 0);
         dlyIn   = DW'($urandom_range(0, 12));
         widIn   = WW'($urandom_range(0, 6));
         armIn   = ($urandom_range(0, 5) == 0);
         trigIn  = ($urandom_range(0, 3) == 0);
         abortIn = ($urandom_range(0, 40) == 0);
         step();
         clearInputs();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
